// File: rtl/snake_board_if.sv
// Game-core to board-stage link: move tick, coordinates and status in,
// update status (busy / self_hit) back to the core.
interface snake_board_if;
    logic       move_clk;
    logic [3:0] head_x;
    logic [3:0] head_y;
    logic [3:0] tail_x;
    logic [3:0] tail_y;
    logic [3:0] apple_x;
    logic [3:0] apple_y;
    logic [1:0] game_state;
    logic       self_hit;
    logic       busy;

    modport master (
        output move_clk, head_x, head_y, tail_x, tail_y, apple_x, apple_y, game_state,
        input  self_hit, busy
    );

    modport slave (
        input  move_clk, head_x, head_y, tail_x, tail_y, apple_x, apple_y, game_state,
        output self_hit, busy
    );
endinterface

// File: rtl/snake_board.sv
// snake_board: 16x16 snake occupancy bitmap updated on each move tick, plus a
// row-multiplexed LED scan with a blinking apple and a blinking dead body.
module snake_board #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 4_000_000
) (
    input  logic         clk,
    input  logic         rst,
    snake_board_if.slave core,
    output logic [15:0]  row_sel,
    output logic [15:0]  col_data
);
    localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ERASE = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_DEAD  = 2'd3;

    // board storage and update bookkeeping
    logic [15:0]        board_q [16];
    logic [15:0]        board_d [16];
    logic [1:0]         state_q, state_d;
    logic [7:0]         h_q, h_d;          // {y, x} of the latched head
    logic [7:0]         t_q, t_d;          // {y, x} of the latched tail
    logic [1:0]         s_q, s_d;
    logic [7:0]         prev_tail_q, prev_tail_d;
    logic               tail_valid_q, tail_valid_d;
    logic               move_q, move_d;
    logic               self_hit_q, self_hit_d;
    logic               busy_q, busy_d;
    logic               move_evt_s;

    // scan / blink / display
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [3:0]         row_q, row_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic [15:0]        row_sel_q, row_sel_d;
    logic [15:0]        col_data_q, col_data_d;
    logic [15:0]        body_s;
    logic [15:0]        apple_s;

    assign move_evt_s    = core.move_clk & ~move_q;
    assign core.self_hit = self_hit_q;
    assign core.busy     = busy_q;
    assign row_sel       = row_sel_q;
    assign col_data      = col_data_q;

    // Move FSM: latch on a tick edge, clear the old tail, then draw the new head.
    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        t_d          = t_q;
        s_d          = s_q;
        prev_tail_d  = prev_tail_q;
        tail_valid_d = tail_valid_q;
        self_hit_d   = 1'b0;
        board_d      = board_q;
        move_d       = core.move_clk;
        case (state_q)
            ST_IDLE: begin
                if (move_evt_s) begin
                    h_d = {core.head_y, core.head_x};
                    t_d = {core.tail_y, core.tail_x};
                    s_d = core.game_state;
                    if (core.game_state == 2'b10) begin
                        state_d = ST_DEAD;
                    end else begin
                        state_d = ST_ERASE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERASE: begin
                // 01 = ate apple: the tail stays so the snake grows by one
                if ((s_q != 2'b01) && tail_valid_q) begin
                    board_d[prev_tail_q[7:4]][prev_tail_q[3:0]] = 1'b0;
                end else begin
                    board_d = board_q;
                end
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                self_hit_d                   = board_q[h_q[7:4]][h_q[3:0]];
                board_d[h_q[7:4]][h_q[3:0]]  = 1'b1;
                prev_tail_d                  = t_q;
                tail_valid_d                 = 1'b1;
                state_d                      = ST_IDLE;
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_ERASE) || (state_d == ST_DRAW);
    end

    // Row scan divider and blink phase divider, both free-running.
    always_comb begin
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = {SCAN_W{1'b0}};
            row_d      = row_q + 4'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
            row_d      = row_q;
        end
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = {BLINK_W{1'b0}};
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            blink_d     = blink_q;
        end
    end

    // Pixel composition for the current row; apple comes from the live inputs.
    always_comb begin
        if ((state_q == ST_DEAD) && (blink_q == 1'b0)) begin
            body_s = 16'h0000;
        end else begin
            body_s = board_q[row_q];
        end
        if ((core.apple_y == row_q) && (blink_q == 1'b1)) begin
            apple_s = 16'h0001 << core.apple_x;
        end else begin
            apple_s = 16'h0000;
        end
        row_sel_d  = 16'h0001 << row_q;
        col_data_d = body_s | apple_s;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                board_q[i] <= 16'h0000;
            end
            state_q      <= ST_IDLE;
            h_q          <= 8'h00;
            t_q          <= 8'h00;
            s_q          <= 2'b00;
            prev_tail_q  <= 8'h00;
            tail_valid_q <= 1'b0;
            move_q       <= 1'b0;
            self_hit_q   <= 1'b0;
            busy_q       <= 1'b0;
            scan_cnt_q   <= {SCAN_W{1'b0}};
            row_q        <= 4'd0;
            blink_cnt_q  <= {BLINK_W{1'b0}};
            blink_q      <= 1'b0;
            row_sel_q    <= 16'h0001;
            col_data_q   <= 16'h0000;
        end else begin
            board_q      <= board_d;
            state_q      <= state_d;
            h_q          <= h_d;
            t_q          <= t_d;
            s_q          <= s_d;
            prev_tail_q  <= prev_tail_d;
            tail_valid_q <= tail_valid_d;
            move_q       <= move_d;
            self_hit_q   <= self_hit_d;
            busy_q       <= busy_d;
            scan_cnt_q   <= scan_cnt_d;
            row_q        <= row_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
        end
    end
endmodule

// File: tb/tb_snake_board.sv
// Testbench for snake_board: randomized moves against a flat-bitmap reference
// model; expected self_hit values are queued at issue time and popped by a
// monitor when each update completes, while the display is compared against
// the model whenever the outputs have settled.
module tb_snake_board;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] row_sel;
    logic [15:0] col_data;

    snake_board_if bus ();

    snake_board #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .core     (bus.slave),
        .row_sel  (row_sel),
        .col_data (col_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n = 0;              // posedges since reset was released
    int quiet_until = 0;    // display checks resume once n reaches this
    bit mon_off = 1'b1;

    // reference model: flat 256-cell bitmap indexed y*16+x
    bit mb [256];
    int m_prev = 0;
    bit m_tv = 1'b0;
    bit m_dead = 1'b0;
    bit exp_q [$];

    always @(posedge clk) begin
        if (!rst) n <= 0;
        else      n <= n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_row(input int y);
        logic [15:0] r;
        for (int x = 0; x < 16; x++) r[x] = mb[y * 16 + x];
        return r;
    endfunction

    // Monitor: pops one expectation per completed update, checks the display.
    initial begin : monitor
        logic busy_prev;
        int   busy_len;
        int   pr;
        int   pb;
        logic [15:0] exp_col;
        busy_prev = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge clk);
            if (!mon_off && rst) begin
                if (busy_prev && !bus.busy) begin
                    check("busy_len", busy_len, 2);
                    check("pending_updates", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) check("self_hit", bus.self_hit, exp_q.pop_front());
                end else begin
                    check("self_hit_idle", bus.self_hit, 1'b0);
                end
                if (m_dead) check("busy_dead", bus.busy, 1'b0);
                if (n >= 1 && n >= quiet_until && !bus.busy) begin
                    pr = ((n - 1) / SCAN_DIV) % 16;
                    pb = ((n - 1) / BLINK_DIV) % 2;
                    check("row_sel", row_sel, 16'h0001 << pr);
                    exp_col = model_row(pr);
                    if (m_dead && pb == 0) exp_col = 16'h0000;
                    if (pb == 1 && int'(bus.apple_y) == pr) exp_col[bus.apple_x] = 1'b1;
                    check("col_data", col_data, exp_col);
                end
                busy_len = bus.busy ? busy_len + 1 : 0;
            end else begin
                busy_len = 0;
            end
            busy_prev = bus.busy;
        end
    end

    task automatic set_apple(input int x, input int y);
        bus.apple_x = 4'(x);
        bus.apple_y = 4'(y);
        quiet_until = n + 3;
        @(negedge clk);
    endtask

    // Issue one move tick; optionally a second rising edge while busy.
    task automatic do_move(input int hx, input int hy, input int tx, input int ty,
                           input logic [1:0] gs, input bit glitch, input int gx, input int gy);
        bus.head_x = 4'(hx); bus.head_y = 4'(hy);
        bus.tail_x = 4'(tx); bus.tail_y = 4'(ty);
        bus.game_state = gs;
        bus.move_clk = 1'b1;
        quiet_until = n + 8;
        if (!m_dead) begin
            if (gs == 2'b10) begin
                m_dead = 1'b1;
            end else begin
                if (gs != 2'b01 && m_tv) mb[m_prev] = 1'b0;
                exp_q.push_back(mb[hy * 16 + hx]);
                mb[hy * 16 + hx] = 1'b1;
                m_prev = ty * 16 + tx;
                m_tv = 1'b1;
            end
        end
        @(negedge clk);
        bus.move_clk = 1'b0;
        @(negedge clk);
        if (glitch) begin
            bus.head_x = 4'(gx); bus.head_y = 4'(gy);
            bus.move_clk = 1'b1;
        end
        @(negedge clk);
        bus.move_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Reset asserted while an update is in ERASE: update must vanish.
    task automatic reset_mid_update(input int hx, input int hy);
        bus.head_x = 4'(hx); bus.head_y = 4'(hy);
        bus.tail_x = 4'(hx); bus.tail_y = 4'(hy);
        bus.game_state = 2'b00;
        bus.move_clk = 1'b1;
        @(negedge clk);
        check("busy_before_abort", bus.busy, 1'b1);
        mon_off = 1'b1;
        bus.move_clk = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("abort_self_hit", bus.self_hit, 1'b0);
        @(negedge clk);
        check("abort_self_hit2", bus.self_hit, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_row_sel", row_sel, 16'h0001);
        check("abort_col_data", col_data, 16'h0000);
        for (int i = 0; i < 256; i++) mb[i] = 1'b0;
        exp_q.delete();
        m_prev = 0; m_tv = 1'b0; m_dead = 1'b0;
        quiet_until = 0;
        rst = 1'b1;
        mon_off = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stimulus
        int hx, hy, tx, ty, r;
        logic [1:0] gs;
        bus.move_clk = 1'b0;
        bus.head_x = 4'd0; bus.head_y = 4'd0;
        bus.tail_x = 4'd0; bus.tail_y = 4'd0;
        bus.apple_x = 4'd15; bus.apple_y = 4'd0;
        bus.game_state = 2'b00;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_row_sel", row_sel, 16'h0001);
        check("rst_col_data", col_data, 16'h0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_self_hit", bus.self_hit, 1'b0);
        rst = 1'b1;
        mon_off = 1'b0;
        repeat (80) @(negedge clk);              // scan wrap and apple blink

        do_move(3, 5, 3, 5, 2'b00, 1'b0, 0, 0);  // first move, no clear
        do_move(4, 5, 4, 5, 2'b00, 1'b0, 0, 0);  // normal move
        do_move(5, 5, 5, 5, 2'b01, 1'b0, 0, 0);  // growth -> 0x30
        do_move(4, 5, 5, 5, 2'b01, 1'b0, 0, 0);  // self hit
        do_move(5, 5, 4, 5, 2'b00, 1'b0, 0, 0);  // head == prev_tail
        do_move(6, 5, 5, 5, 2'b00, 1'b1, 9, 9);  // edge during busy dropped
        do_move(7, 5, 6, 5, 2'b11, 1'b0, 0, 0);  // 11 behaves as 00
        set_apple(7, 5);                         // apple on a body cell
        repeat (70) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 2);
            gs = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
            if ($urandom_range(0, 1) == 1) begin
                hx = $urandom_range(0, 3); hy = $urandom_range(0, 3);
            end else begin
                hx = $urandom_range(0, 15); hy = $urandom_range(0, 15);
            end
            tx = $urandom_range(0, 3); ty = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) set_apple($urandom_range(0, 15), $urandom_range(0, 15));
            do_move(hx, hy, tx, ty, gs, ($urandom_range(0, 4) == 0),
                    $urandom_range(0, 15), $urandom_range(0, 15));
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        repeat (70) @(negedge clk);

        reset_mid_update(8, 8);
        repeat (70) @(negedge clk);

        set_apple(15, 0);
        do_move(4, 5, 4, 5, 2'b00, 1'b0, 0, 0);
        do_move(5, 5, 4, 5, 2'b01, 1'b0, 0, 0);  // body 0x30 in row 5
        do_move(6, 5, 5, 5, 2'b10, 1'b0, 0, 0);  // dead, frozen
        do_move(7, 5, 6, 5, 2'b00, 1'b0, 0, 0);  // ignored
        do_move(8, 6, 7, 5, 2'b01, 1'b1, 9, 9);  // ignored
        repeat (90) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
